// File: rtl/unused_name_filter.sv
// Streaming ignore-pattern filter for identifier names.
// Each slot holds an exact, prefix or suffix pattern; one result is produced per name.
module unused_name_filter #(
    parameter int unsigned NUM_PATTERNS = 4,
    parameter int unsigned PAT_LEN      = 16,
    parameter int unsigned MAX_NAME_LEN = 64,
    localparam int unsigned IW = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
    localparam int unsigned CW = $clog2(PAT_LEN + 1),
    localparam int unsigned LW = $clog2(MAX_NAME_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    output logic                    cfg_ready,
    input  logic [IW-1:0]           cfg_idx,
    input  logic [1:0]              cfg_mode,
    input  logic [CW-1:0]           cfg_len,
    input  logic [8*PAT_LEN-1:0]    cfg_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_data,
    input  logic                    in_last,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [NUM_PATTERNS-1:0] res_match,
    output logic                    res_ignored,
    output logic [LW-1:0]           res_len,
    output logic                    res_overflow
);

    localparam logic [1:0]    ModeExact  = 2'd1;
    localparam logic [1:0]    ModePrefix = 2'd2;
    localparam logic [1:0]    ModeSuffix = 2'd3;
    localparam logic [CW-1:0] PatLenMax  = CW'(PAT_LEN);
    localparam logic [LW-1:0] NameLenMax = LW'(MAX_NAME_LEN);

    typedef enum logic [1:0] {StIdle, StRecv, StEval, StResult} state_e;

    state_e state_q, state_d;

    logic [1:0]           mode_q   [NUM_PATTERNS];
    logic [CW-1:0]        len_q    [NUM_PATTERNS];
    logic [8*PAT_LEN-1:0] data_q   [NUM_PATTERNS];
    logic [CW-1:0]        eff_len  [NUM_PATTERNS];
    logic [8*PAT_LEN-1:0] eff_data [NUM_PATTERNS];

    logic [LW-1:0]           pos_q, pos_d, byte_pos;
    logic                    ovf_q, ovf_d;
    logic [NUM_PATTERNS-1:0] pok_q, pok_d;
    // Newest byte sits in the top byte lane.
    logic [8*PAT_LEN-1:0]    hist_q, hist_d;
    logic [NUM_PATTERNS-1:0] match;

    logic [NUM_PATTERNS-1:0] res_match_q;
    logic                    res_ignored_q;
    logic [LW-1:0]           res_len_q;
    logic                    res_overflow_q;

    logic          cfg_fire, in_fire;
    logic [CW-1:0] cfg_len_clamped;

    assign cfg_fire        = cfg_we && cfg_ready;
    assign in_fire         = in_valid && in_ready;
    assign cfg_len_clamped = (cfg_len > PatLenMax) ? PatLenMax : cfg_len;

    assign res_match    = res_match_q;
    assign res_ignored  = res_ignored_q;
    assign res_len      = res_len_q;
    assign res_overflow = res_overflow_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic: one name at a time, no overlap with the pending result.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (in_fire) state_d = in_last ? StEval : StRecv;
            StRecv:   if (in_fire && in_last) state_d = StEval;
            StEval:   state_d = StResult;
            StResult: if (res_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = 1'b0;
        cfg_ready = 1'b0;
        res_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready  = 1'b1;
                cfg_ready = 1'b1;
            end
            StRecv:   in_ready  = 1'b1;
            StResult: res_valid = 1'b1;
            default: ;
        endcase
    end

    // Pattern slot storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PATTERNS; k++) begin
                mode_q[k] <= '0;
                len_q[k]  <= '0;
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_PATTERNS; k++) begin
                if (cfg_fire && cfg_idx == IW'(k)) begin
                    mode_q[k] <= cfg_mode;
                    len_q[k]  <= cfg_len_clamped;
                    data_q[k] <= cfg_data;
                end
            end
        end
    end

    // Bypass a same-cycle write so a name starting on that edge sees the new pattern.
    always_comb begin
        for (int k = 0; k < NUM_PATTERNS; k++) begin
            eff_len[k]  = len_q[k];
            eff_data[k] = data_q[k];
            if (cfg_fire && cfg_idx == IW'(k)) begin
                eff_len[k]  = cfg_len_clamped;
                eff_data[k] = cfg_data;
            end
        end
    end

    // Per-byte tracking: position, overflow, prefix agreement and tail history.
    always_comb begin
        pos_d    = pos_q;
        ovf_d    = ovf_q;
        pok_d    = pok_q;
        hist_d   = hist_q;
        byte_pos = (state_q == StIdle) ? '0 : pos_q;
        if (in_fire) begin
            hist_d = {in_data, hist_q[8*PAT_LEN-1:8]};
            if (state_q == StIdle) begin
                ovf_d = 1'b0;
                pok_d = '1;
            end
            if (byte_pos == NameLenMax) begin
                pos_d = NameLenMax;
                ovf_d = 1'b1;
            end else begin
                pos_d = byte_pos + LW'(1);
            end
            for (int k = 0; k < NUM_PATTERNS; k++) begin
                for (int i = 0; i < PAT_LEN; i++) begin
                    if (byte_pos == LW'(i) && CW'(i) < eff_len[k] &&
                        in_data != eff_data[k][8*i +: 8]) begin
                        pok_d[k] = 1'b0;
                    end
                end
            end
        end
    end

    // Name tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q  <= '0;
            ovf_q  <= 1'b0;
            pok_q  <= '0;
            hist_q <= '0;
        end else begin
            pos_q  <= pos_d;
            ovf_q  <= ovf_d;
            pok_q  <= pok_d;
            hist_q <= hist_d;
        end
    end

    // Match evaluation; a saturated pos still satisfies n>=len since len <= PAT_LEN.
    always_comb begin
        logic [8*PAT_LEN-1:0] win;
        logic                 n_ge;
        logic                 sfx_ok;
        match = '0;
        for (int k = 0; k < NUM_PATTERNS; k++) begin
            // Align the last len bytes so pattern byte 0 lands in lane 0.
            win    = hist_q >> (8 * (PAT_LEN - int'(len_q[k])));
            n_ge   = pos_q >= LW'(len_q[k]);
            sfx_ok = 1'b1;
            for (int i = 0; i < PAT_LEN; i++) begin
                if (CW'(i) < len_q[k] && win[8*i +: 8] != data_q[k][8*i +: 8]) sfx_ok = 1'b0;
            end
            unique case (mode_q[k])
                ModeExact:  match[k] = pok_q[k] && pos_q == LW'(len_q[k]) && !ovf_q;
                ModePrefix: match[k] = pok_q[k] && n_ge;
                ModeSuffix: match[k] = sfx_ok && n_ge;
                default:    match[k] = 1'b0;
            endcase
        end
    end

    // Result registers, loaded once per name in the evaluation cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_match_q    <= '0;
            res_ignored_q  <= 1'b0;
            res_len_q      <= '0;
            res_overflow_q <= 1'b0;
        end else if (state_q == StEval) begin
            res_match_q    <= match;
            res_ignored_q  <= |match;
            res_len_q      <= pos_q;
            res_overflow_q <= ovf_q;
        end
    end

endmodule

// File: tb/tb_unused_name_filter.sv
// Self-checking bench for unused_name_filter: directed steps plus random names
// compared against a string-level reference model.
module tb_unused_name_filter;

    localparam int NP = 4;
    localparam int PL = 16;
    localparam int ML = 64;
    localparam int IW = $clog2(NP);
    localparam int CW = $clog2(PL + 1);
    localparam int LW = $clog2(ML + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            cfg_we = 1'b0;
    logic            cfg_ready;
    logic [IW-1:0]   cfg_idx = '0;
    logic [1:0]      cfg_mode = '0;
    logic [CW-1:0]   cfg_len = '0;
    logic [8*PL-1:0] cfg_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [7:0]      in_data = '0;
    logic            in_last = 1'b0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [NP-1:0]   res_match;
    logic            res_ignored;
    logic [LW-1:0]   res_len;
    logic            res_overflow;

    int npass  = 0;
    int ntotal = 0;

    // Reference model state: mode, clamped length and bytes per slot.
    int  m_mode [NP];
    int  m_len  [NP];
    byte m_pat  [NP][PL];

    string frags [8] = '{"unused_", "_debug", "clk", "_reserved", "ab", "*", "x", "_"};

    unused_name_filter #(
        .NUM_PATTERNS (NP),
        .PAT_LEN      (PL),
        .MAX_NAME_LEN (ML)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_we       (cfg_we),
        .cfg_ready    (cfg_ready),
        .cfg_idx      (cfg_idx),
        .cfg_mode     (cfg_mode),
        .cfg_len      (cfg_len),
        .cfg_data     (cfg_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_match    (res_match),
        .res_ignored  (res_ignored),
        .res_len      (res_len),
        .res_overflow (res_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [NP-1:0] ref_match(input string nm);
        logic [NP-1:0] m;
        int n;
        int l;
        bit pre;
        bit suf;
        m = '0;
        n = nm.len();
        for (int k = 0; k < NP; k++) begin
            l   = m_len[k];
            pre = 1'b1;
            suf = 1'b1;
            for (int i = 0; i < l; i++) begin
                if (i >= n || nm[i] != m_pat[k][i]) pre = 1'b0;
                if (n - l + i < 0 || nm[n-l+i] != m_pat[k][i]) suf = 1'b0;
            end
            case (m_mode[k])
                1:       m[k] = pre && n == l && n <= ML;
                2:       m[k] = pre && n >= l;
                3:       m[k] = suf && n >= l;
                default: m[k] = 1'b0;
            endcase
        end
        return m;
    endfunction

    // Drive a config write (and update the model) without advancing the clock.
    task automatic cfg_drive(input int idx, input int mode, input int len, input string s);
        cfg_we   = 1'b1;
        cfg_idx  = IW'(idx);
        cfg_mode = 2'(mode);
        cfg_len  = CW'(len);
        for (int i = 0; i < PL; i++) begin
            if (i < s.len()) cfg_data[8*i +: 8] = s[i];
            else             cfg_data[8*i +: 8] = 8'($urandom_range(33, 126));
            m_pat[idx][i] = byte'(cfg_data[8*i +: 8]);
        end
        m_mode[idx] = mode;
        m_len[idx]  = (len > PL) ? PL : len;
    endtask

    task automatic cfg_write(input int idx, input int mode, input int len, input string s);
        cfg_drive(idx, mode, len, s);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    // Stream a name; poke attempts a config write while in RECV, which must be ignored.
    task automatic send_name(input string nm, input bit poke);
        int gap;
        for (int i = 0; i < nm.len(); i++) begin
            if (i > 0) begin
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                    check("recv_in_ready", in_ready, 1);
                end
            end
            in_valid = 1'b1;
            in_data  = nm[i];
            in_last  = (i == nm.len() - 1);
            if (poke && i == 1) begin
                cfg_we   = 1'b1;
                cfg_idx  = '0;
                cfg_mode = 2'd1;
                cfg_len  = CW'(3);
                cfg_data = {8{16'h7a7a}};
                check("recv_cfg_ready", cfg_ready, 0);
            end
            @(posedge clk);
            #1;
            cfg_we = 1'b0;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_name(input string nm, input int hold, input bit poke, input int lit);
        logic [NP-1:0] exp;
        logic [NP-1:0] snap_m;
        logic [LW-1:0] snap_l;
        int n;
        int c;
        send_name(nm, poke);
        check("eval_res_valid", res_valid, 0);
        check("eval_in_ready", in_ready, 0);
        c = 0;
        while (!res_valid && c < 8) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("res_latency", c, 1);
        exp = ref_match(nm);
        n   = nm.len();
        check("res_match", res_match, exp);
        check("res_ignored", res_ignored, |exp);
        check("res_len", res_len, (n > ML) ? ML : n);
        check("res_overflow", res_overflow, n > ML);
        if (lit >= 0) check("res_match_lit", res_match, lit);
        snap_m = res_match;
        snap_l = res_len;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", res_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_match", res_match, exp);
            check("hold_len", res_len, (n > ML) ? ML : n);
            check("hold_stable", {snap_m, snap_l}, {res_match, res_len});
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("idle_in_ready", in_ready, 1);
        check("idle_cfg_ready", cfg_ready, 1);
    endtask

    function automatic string rand_name();
        string s;
        int nf;
        s  = "";
        nf = $urandom_range(1, 4);
        for (int i = 0; i < nf; i++) s = {s, frags[$urandom_range(0, 7)]};
        if ($urandom_range(0, 5) == 0) begin
            while (s.len() < 66) s = {s, "ab"};
            s = {s, frags[$urandom_range(0, 7)]};
        end
        return s;
    endfunction

    initial begin
        string long_nm;
        string f;
        for (int k = 0; k < NP; k++) begin
            m_mode[k] = 0;
            m_len[k]  = 0;
        end

        // Reset: asynchronous assertion, then release.
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_in_ready", in_ready, 1);
        check("rst_async_res_valid", res_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_match", res_match, 0);
        check("rst_res_ignored", res_ignored, 0);
        check("rst_res_len", res_len, 0);
        check("rst_res_overflow", res_overflow, 0);

        // Directed prefix / suffix / exact cases.
        cfg_write(0, 2, 7, "unused_");
        cfg_write(1, 3, 6, "_debug");
        cfg_write(2, 3, 9, "_reserved");
        cfg_write(3, 1, 3, "clk");
        run_name("unused_for_debug", 5, 1'b0, 4'b0011);
        run_name("future_reserved", 0, 1'b0, 4'b0100);
        run_name("actually_unused_signal", 0, 1'b0, 4'b0000);
        run_name("clk", 0, 1'b0, 4'b1000);
        run_name("clk2", 0, 1'b0, 4'b0000);
        run_name("dbg", 0, 1'b0, 4'b0000);
        run_name("x", 0, 1'b0, 4'b0000);
        long_nm = "";
        for (int i = 0; i < 64; i++) long_nm = {long_nm, "a"};
        long_nm = {long_nm, "_debug"};
        run_name(long_nm, 0, 1'b0, 4'b0010);

        // Config write in RECV must not land; slot 0 keeps its prefix.
        run_name("unused_q", 0, 1'b1, 4'b0001);

        // Config write on the same edge as a first byte is seen by that name.
        cfg_drive(2, 2, 2, "fu");
        run_name("fun", 0, 1'b0, 4'b0100);
        cfg_write(2, 3, 9, "_reserved");

        // Random configs and names.
        for (int r = 0; r < 40; r++) begin
            if (r % 5 == 0) begin
                f = frags[$urandom_range(0, 7)];
                cfg_write($urandom_range(0, NP - 1), $urandom_range(0, 3),
                          ($urandom_range(0, 1) == 0) ? f.len() : $urandom_range(0, 20), f);
            end
            run_name(rand_name(), $urandom_range(0, 3), 1'b0, -1);
        end

        // Reset mid-name: no result, patterns cleared.
        cfg_write(0, 2, 7, "unused_");
        in_valid = 1'b1;
        in_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(f.len() == 99 ? 0 : "unu" >> (8 * (2 - i)));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_res_valid", res_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_cfg_ready", cfg_ready, 1);
        check("midrst_res_match", res_match, 0);
        check("midrst_res_len", res_len, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < NP; k++) m_mode[k] = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("midrst_no_result", res_valid, 0);
        end
        run_name("unused_a", 0, 1'b0, 4'b0000);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
